// File: rtl/countdown_sequencer_pkg.sv
// Shared definitions for the countdown sequencer slice.
// Holds the FSM state encodings, the default width and default-load constants,
// and COUNTDOWN_CHECK_PARAMS, an elaboration check that DEFAULT_LOAD fits in WIDTH bits.
// Optional feature macro used by the slice: COUNTDOWN_AUTO_RELOAD_EN (see countdown_sequencer.sv).
`ifndef COUNTDOWN_SEQUENCER_PKG_SV
`define COUNTDOWN_SEQUENCER_PKG_SV

// Expands to a generate block that stops elaboration when the default load
// cannot be represented in the counter width.
`define COUNTDOWN_CHECK_PARAMS(w_, d_) \
  if ((d_) >= (64'd1 << (w_))) begin : g_bad_default_load \
    $error("DEFAULT_LOAD must be below 2**WIDTH"); \
  end

package countdown_sequencer_pkg;

  localparam int unsigned CNT_WIDTH_DEFAULT = 6;
  localparam int unsigned DEFAULT_LOAD      = 32;

  localparam logic [1:0] STATE_IDLE = 2'b00;
  localparam logic [1:0] STATE_RUN  = 2'b01;
  localparam logic [1:0] STATE_DONE = 2'b10;

endpackage

`endif

// File: rtl/sync_down_counter.sv
// Loadable synchronous down-counter with a ripple-borrow decrement chain.
// Ports:
//   clock    - rising-edge clock
//   clr      - asynchronous active-high clear (count -> 0)
//   load     - synchronous load; has priority over enable
//   load_val - value captured on load
//   enable   - decrement qualifier
//   count    - registered count
module sync_down_counter #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] borrow;

  // Bit i toggles when every lower bit is zero: the borrow ripples up through
  // the trailing zeros. Each term is formed directly from the lower bits so the
  // chain has no combinational self-reference.
  assign borrow[0] = enable;
  for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
    assign borrow[i] = enable & ~(|count_q[i-1:0]);
  end

  assign count_d = load ? load_val : (count_q ^ borrow);

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      count_q <= '0;
    end else if (load || enable) begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/countdown_sequencer.sv
// Countdown sequencer: loads an iteration count on start, counts down on enabled
// cycles and emits a one-cycle done pulse when the count is exhausted.
// Ports:
//   clock, clr           - clock and asynchronous active-high reset
//   start, load_val      - begin a countdown with load_val (accepted in IDLE and DONE)
//   use_default          - substitute DEFAULT_LOAD when load_val == 0
//   enable, abort        - advance qualifier; cancel (highest synchronous priority)
//   count, busy, done    - registered remaining count, RUN flag, DONE pulse
//   last                 - combinational: final enabled RUN cycle
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to restart from the last
// accepted load whenever DONE is left without start or abort.
module countdown_sequencer #(
  parameter int unsigned WIDTH        = countdown_sequencer_pkg::CNT_WIDTH_DEFAULT,
  parameter int unsigned DEFAULT_LOAD = countdown_sequencer_pkg::DEFAULT_LOAD
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             use_default,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             last
);
  import countdown_sequencer_pkg::*;

  `COUNTDOWN_CHECK_PARAMS(WIDTH, DEFAULT_LOAD)

  localparam logic [WIDTH-1:0] DefaultLoadW = WIDTH'(DEFAULT_LOAD);
  localparam logic [WIDTH-1:0] CountOne     = WIDTH'(1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] eff_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_load;
  logic             cnt_dec;

  assign eff_load = ((load_val == '0) && use_default) ? DefaultLoadW : load_val;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic             accept;

  // Abort in IDLE is ignored, so start is accepted there regardless of abort.
  assign accept = start & ((state_q == STATE_IDLE) |
                           ((state_q == STATE_DONE) & ~abort));

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      reload_q <= '0;
    end else if (accept) begin
      reload_q <= eff_load;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        if (start) begin
          cnt_load     = 1'b1;
          cnt_load_val = eff_load;
          state_d      = (eff_load == '0) ? STATE_DONE : STATE_RUN;
        end
      end
      STATE_RUN: begin
        if (abort) begin
          cnt_load = 1'b1;
          state_d  = STATE_IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        end else if (count == '0) begin
          // Only reachable via a zero reload: one RUN cycle, then DONE again.
          state_d = STATE_DONE;
`endif
        end else if (enable) begin
          cnt_dec = 1'b1;
          if (count == CountOne) begin
            state_d = STATE_DONE;
          end
        end
      end
      STATE_DONE: begin
        if (abort) begin
          state_d = STATE_IDLE;
        end else if (start) begin
          cnt_load     = 1'b1;
          cnt_load_val = eff_load;
          state_d      = (eff_load == '0) ? STATE_DONE : STATE_RUN;
        end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          cnt_load     = 1'b1;
          cnt_load_val = reload_q;
          state_d      = STATE_RUN;
`else
          state_d = STATE_IDLE;
`endif
        end
      end
      default: begin
        // Unreachable encoding: recover to IDLE with a cleared count.
        cnt_load = 1'b1;
        state_d  = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q <= STATE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  sync_down_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clock    (clock),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .enable   (cnt_dec),
    .count    (count)
  );

  assign busy = (state_q == STATE_RUN);
  assign done = (state_q == STATE_DONE);
  assign last = busy & enable & (count == CountOne);

endmodule

// File: tb/tb_countdown_sequencer.sv
// Scoreboard bench for countdown_sequencer: a behavioural model predicts the
// registered outputs after each edge; a negedge monitor pops and compares.
module tb_countdown_sequencer;

  localparam int W       = 6;
  localparam int DEFLOAD = 32;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         clr;
  logic         start;
  logic [W-1:0] load_val;
  logic         use_default;
  logic         enable;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         last;

  countdown_sequencer #(
    .WIDTH        (W),
    .DEFAULT_LOAD (DEFLOAD)
  ) dut (
    .clock       (clock),
    .clr         (clr),
    .start       (start),
    .load_val    (load_val),
    .use_default (use_default),
    .enable      (enable),
    .abort       (abort),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .last        (last)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] count;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  // Reference model: remaining budget plus running/done flags.
  int m_rem    = 0;
  bit m_run    = 1'b0;
  bit m_done   = 1'b0;
  int m_reload = 0;

  function automatic int effective(int lv, bit ud);
    return (lv == 0 && ud) ? (DEFLOAD % (1 << W)) : lv;
  endfunction

  task automatic model_reset();
    m_rem = 0; m_run = 1'b0; m_done = 1'b0; m_reload = 0;
  endtask

  task automatic model_step(bit s, int lv, bit ud, bit en, bit ab);
    int n;
    n = effective(lv, ud);
    if (m_run) begin
      if (ab) begin
        m_run = 1'b0; m_rem = 0;
      end else if (m_rem == 0) begin
        m_run = 1'b0; m_done = 1'b1;
      end else if (en) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_run = 1'b0; m_done = 1'b1;
        end
      end
    end else if (m_done && ab) begin
      m_done = 1'b0; m_rem = 0;
    end else if (s) begin
      m_reload = n; m_rem = n; m_run = (n > 0); m_done = (n == 0);
    end else if (m_done && AUTO) begin
      m_rem = m_reload; m_run = 1'b1; m_done = 1'b0;
    end else begin
      m_done = 1'b0; m_rem = 0;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.count = W'(m_rem);
    e.busy  = m_run;
    e.done  = m_done;
    return e;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endfunction

  always @(negedge clock) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty at %0t: got no entry expected one", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("count", 32'(count), 32'(mon_e.count));
        check("busy",  32'(busy),  32'(mon_e.busy));
        check("done",  32'(done),  32'(mon_e.done));
        check("last",  32'(last),
              32'(mon_e.busy & enable & (mon_e.count == W'(1))));
      end
    end
  end

  // Drive one cycle of inputs, predict the state after the next edge, advance.
  task automatic cyc(bit s, int lv, bit ud, bit en, bit ab);
    start = s; load_val = W'(lv); use_default = ud; enable = en; abort = ab;
    model_step(s, lv, ud, en, ab);
    exp_q.push_back(model_out());
    @(posedge clock);
    #1;
  endtask

  task automatic idle(int n, bit en);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, en, 1'b0);
  endtask

  // Asynchronous clear in the middle of a cycle, checked immediately.
  task automatic clr_now();
    mon_en = 1'b0;
    start = 1'b0; abort = 1'b0; enable = 1'b1; use_default = 1'b0; load_val = '0;
    #1 clr = 1'b1;
    #1;
    check("clr_count", 32'(count), 32'd0);
    check("clr_busy",  32'(busy),  32'd0);
    check("clr_done",  32'(done),  32'd0);
    clr = 1'b0;
    exp_q.delete();
    model_reset();
    exp_q.push_back(model_out());
    mon_en = 1'b1;
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; load_val = '0; use_default = 1'b0;
    enable = 1'b0; abort = 1'b0;
    #1 clr = 1'b1;
    #1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_done",  32'(done),  32'd0);
    check("reset_last",  32'(last),  32'd0);
    @(posedge clock);
    #1;
    clr = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
    mon_en = 1'b1;

    // Basic countdown from 5.
    cyc(1'b1, 5, 1'b0, 1'b1, 1'b0);
    idle(7, 1'b1);
    // Stall for two cycles at count 2.
    cyc(1'b1, 3, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(5, 1'b1);
    // Zero load straight to DONE, then default load of 32.
    cyc(1'b1, 0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);
    cyc(1'b1, 0, 1'b1, 1'b1, 1'b0);
    idle(36, 1'b1);
    // Abort at count 4 with start also high.
    cyc(1'b1, 8, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b1);
    cyc(1'b1, 9, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);
    // Back-to-back start in the DONE cycle.
    cyc(1'b1, 2, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    cyc(1'b1, 2, 1'b0, 1'b1, 1'b0);
    idle(5, 1'b1);
    // Auto-reload sequence (single pulse when the feature is off), then abort.
    cyc(1'b1, 3, 1'b0, 1'b1, 1'b0);
    idle(14, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
    idle(6, 1'b1);
    // Clear mid-run at count 6; no done pulse may follow.
    cyc(1'b1, 10, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b1);
    check("pre_clr_count", 32'(count), 32'd6);
    clr_now();
    idle(12, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      int lv;
      lv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                       : int'($urandom_range(0, 6));
      cyc(($urandom_range(0, 4) == 0), lv, ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end
    clr_now();
    idle(3, 1'b1);

    @(negedge clock);
    #1;
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
Loadable WIDTH-bit synchronous down-counter with start/busy/done handshake. It sequences multicycle datapath operations such as multdiv iterations and stall windows. The issuing control logic loads an iteration count, and the block then counts down on enabled cycles. A single-cycle done pulse is raised when the count reaches zero. Pairs with the existing up-counter: the up-counter measures elapsed cycles; this block enforces a preset remaining-cycle budget.

Parameters:
WIDTH, 6, counter width in bits; maximum load value 2^WIDTH-1
DEFAULT_LOAD, 32, count substituted when start arrives with load_val == 0 and use_default = 1

Ports:
clock  input  1  rising-edge clock, sole clock domain
clr  input  1  asynchronous active-high reset
start  input  1  request to begin a countdown; sampled in IDLE and DONE only
load_val  input  WIDTH  initial count, sampled with start
use_default  input  1  when 1 and load_val == 0, load DEFAULT_LOAD instead of 0
enable  input  1  count-advance qualifier; 0 holds count and state in RUN
abort  input  1  cancel the current countdown; highest synchronous priority
count  output  WIDTH  remaining count, registered
busy  output  1  high in RUN
done  output  1  one-cycle pulse in DONE
last  output  1  combinational, = busy & enable & (count == 1); early-warning for datapath writeback

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named clock and clr. clr forces count=0, busy=0, done=0, state=IDLE immediately, including mid-countdown.
- States (2-bit encoding): IDLE=00, RUN=01, DONE=10; 11 is unreachable and recovers to IDLE on the next edge.
- Priority each edge: clr (async) > abort > start > enable.
- IDLE:
  - start=1 with effective load N>0: count<=N, go to RUN.
  - start=1 with effective load N=0: count<=0, go straight to DONE (done pulse next cycle, busy never rises).
  - abort in IDLE has no effect.
- RUN:
  - busy=1. enable=1: count<=count-1. enable=0: count holds.
  - enable=1 with count==1: count<=0, go to DONE.
  - abort=1: count<=0, go to IDLE, no done pulse.
  - start is ignored; no reload mid-run.
- DONE:
  - done=1 and busy=0 for exactly one cycle, count=0.
  - Next edge returns to IDLE, unless start=1, which is accepted back-to-back exactly as in IDLE.
  - abort in DONE returns to IDLE; the done pulse of the current cycle still completes.
- Latency: start at edge T with N>0 and enable held high gives:
  - count=N at T+1, decrementing by 1 per cycle;
  - busy high for cycles T+1..T+N;
  - done high in cycle T+N+1.
- Arithmetic: decrement is modulo 2^WIDTH but never wraps in practice, since RUN exits at count 1. Effective load is truncated to WIDTH bits; DEFAULT_LOAD must be < 2^WIDTH (elaboration check).
- Outputs count, busy and done are registered; only last is combinational.

Optional Feature:
Macro COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - A WIDTH-bit reload register captures the effective load on every accepted start.
  - In DONE with no new start and no abort, the block reloads count from that register and re-enters RUN next cycle, producing periodic done pulses every N+1 cycles.
  - abort still returns to IDLE.
  - A reload value of 0 yields a done pulse every other cycle.
- Undefined: the reload register is absent and DONE always returns to IDLE as above.

Decomposition:
- Shared package/header holds:
  - state encodings STATE_IDLE, STATE_RUN, STATE_DONE;
  - CNT_WIDTH_DEFAULT=6 and DEFAULT_LOAD constants;
  - the WIDTH/DEFAULT_LOAD elaboration-check macro.
- One sub-module: sync_down_counter, WIDTH loadable flops plus a ripple-borrow decrement chain.
  - Borrow into bit i is the AND of the inverted lower bits, gated by enable.
  - Built on dffe_ref with load mux, enable and clr.
- The top level holds the FSM, handshake logic and optional reload register.

Test Plan:
- Reset mid-run: load 10, assert clr at count=6 -> count=0, busy=0, done=0 immediately, with no done pulse afterward.
- Basic countdown: start, load_val=5, enable=1 -> count 5,4,3,2,1 with busy high 5 cycles; done in cycle 6; last high when count=1.
- Stall: load 3, enable low for 2 cycles at count=2 -> count holds 2, busy stays 1; done arrives 2 cycles later (cycle 6).
- Zero/default load:
  - load_val=0, use_default=0 -> done at T+1, busy never high.
  - load_val=0, use_default=1 -> count=32 at T+1, done at T+33.
- Abort and back-to-back:
  - abort at count=4 with start also high -> IDLE, count=0, no done.
  - start in DONE cycle with load 2 -> count=2 next cycle, done 3 cycles later.
- Auto-reload (macro on): load 3 -> done pulses in cycles T+4, T+8, T+12; abort stops the sequence; with the macro off, only the T+4 pulse occurs.
